// File: rtl/uart_tx_engine.sv
// uart_tx_engine: drains a show-ahead FIFO onto TXD as start, 8 data (LSB first), optional parity, stop.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx_engine (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iREMOVE,
    input  logic        iTX_EN,
    input  logic [15:0] iBAUD_DIV,
    input  logic        iFIFO_EMPTY,
    input  logic [7:0]  iFIFO_DATA,
    output logic        oFIFO_RD,
    output logic        oUART_TXD,
    output logic        oBUSY,
    output logic        oDONE
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d, baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic        tick, par_bit;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
    assign par_bit = par_q;
    always_ff @(posedge iCLOCK or negedge inRESET)
        if (!inRESET) par_q <= 1'b0;
        else          par_q <= par_d;
`else
    assign par_bit = 1'b1;
`endif
    assign tick  = baud_q == div_q;
    assign oBUSY = state_q != IDLE;
    // TXD is decoded from state so an asynchronous reset drives it high without a clock
    assign oUART_TXD = (state_q == START) ? 1'b0 :
                       (state_q == DATA) ? shift_q[0] :
                       (state_q == PARITY) ? par_bit : 1'b1;
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= IDLE;
            shift_q <= '0;
            div_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        div_d    = div_q;
        bit_d    = bit_q;
        baud_d   = tick ? '0 : baud_q + 16'd1;
        oFIFO_RD = 1'b0;
        oDONE    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (iREMOVE) begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_d = '0;
                    if (iTX_EN && !iFIFO_EMPTY) begin
                        oFIFO_RD = 1'b1;
                        shift_d  = iFIFO_DATA;
                        div_d    = iBAUD_DIV;
                        bit_d    = '0;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^iFIFO_DATA;
`endif
                        state_d  = START;
                    end
                end
                START:  if (tick) state_d = DATA;
                DATA: begin
                    if (tick) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                        if (bit_q == 3'd7) state_d = PARITY;
`else
                        if (bit_q == 3'd7) state_d = STOP;
`endif
                    end
                end
                PARITY: if (tick) state_d = STOP;
                STOP: begin
                    oDONE = tick;
                    if (tick) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

UART transmit serializer that drains the SCI transmit FIFO. Whenever enabled and the FIFO is non-empty, it pops one byte through the FIFO read port and shifts it out on the TXD line as a start bit, 8 data bits LSB-first, an optional parity bit and one stop bit. The bit rate comes from a programmable cycle divisor. It sits between the TX-side synchronous FIFO's read port and the SCI pin.

## Interface
Parameters:
- none (frame format fixed at 8 data bits, 1 stop bit; parity selected by macro)

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  asynchronous active-low reset
- iREMOVE  in  1  synchronous abort; high forces IDLE, TXD high
- iTX_EN  in  1  transmit enable; sampled only in IDLE
- iBAUD_DIV  in  16  cycles per bit minus 1; latched at frame start
- iFIFO_EMPTY  in  1  FIFO read-side empty flag
- iFIFO_DATA  in  8  FIFO head data (show-ahead: valid while not empty)
- oFIFO_RD  out  1  FIFO pop strobe, one cycle per frame
- oUART_TXD  out  1  serial output, idle high
- oBUSY  out  1  high whenever state != IDLE
- oDONE  out  1  one-cycle pulse on the last cycle of the stop bit

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - oFIFO_RD = iTX_EN & ~iFIFO_EMPTY & ~iREMOVE (combinational).
  - In the same cycle, latch iFIFO_DATA into the shift register, latch iBAUD_DIV into the divisor register, clear the baud and bit counters, and go to START.
- Baud counter counts 0..div_latched. The bit tick is counter == div_latched. The counter reloads to 0 on each tick.
- START: TXD = 0 for one bit time, then go to DATA.
- DATA:
  - TXD = shift_reg[0]; shift right on each tick.
  - The 3-bit bit counter increments on each tick; after the 8th tick go to PARITY if compiled in, else STOP.
- PARITY: TXD = parity of the latched byte for one bit time, then go to STOP.
- STOP: TXD = 1 for one bit time. oDONE is high on the tick cycle, then go to IDLE.
- iTX_EN deasserted mid-frame: the frame completes; no further pop.
- iREMOVE (priority below reset, above all else): next edge goes to IDLE, TXD = 1, counters cleared, no pop that cycle. A partial frame is truncated.
- oFIFO_RD is never asserted outside IDLE, so exactly one pop occurs per frame.

## Timing
- Reset values: oUART_TXD = 1, oBUSY = 0, oDONE = 0, oFIFO_RD = 0 (inRESET low forces IDLE); shift register and all counters are 0.
- Asynchronous reset mid-frame: TXD returns high immediately, with no clock needed.
- Pop in cycle N → TXD = 0 and oBUSY = 1 from cycle N+1.
- Bit time = iBAUD_DIV + 1 cycles. iBAUD_DIV = 0 gives 1 cycle per bit, which is legal.
- Frame length = (10 + P) × (div + 1) cycles, with P = 1 if parity is compiled in, else 0.
- Back-to-back frames: after STOP the engine is in IDLE for at least one cycle (TXD high), and pops at the earliest in that cycle. Consecutive start bits are therefore (10 + P) × (div + 1) + 1 cycles apart.
- iBAUD_DIV changes mid-frame have no effect until the next frame.

## Configuration
- Macro: UART_TX_PARITY_EN.
  - Defined: the PARITY state is present; the parity bit is even (XOR of the 8 data bits) and is sent after data bit 7. Frame = 11 bit times.
  - Undefined: no PARITY state; DATA goes directly to STOP. Frame = 10 bit times.

## Test plan
- Reset check: inRESET low, then high with FIFO empty and iTX_EN = 1 → TXD = 1, oBUSY = 0 and oFIFO_RD = 0 for 100 cycles.
- Single byte 0xA5, iBAUD_DIV = 3, no parity:
  - Exactly one oFIFO_RD pulse.
  - TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - oDONE pulses on cycle 40 after the pop.
- Same byte with UART_TX_PARITY_EN: parity bit 0 (0xA5 has 4 ones) inserted before stop, 44 cycles total. Byte 0x01 → parity bit 1.
- Three queued bytes 0x00, 0xFF, 0x55, iBAUD_DIV = 0:
  - Three pops.
  - Start bits 11 cycles apart (no parity).
  - Serial data matches LSB-first.
- Disruption:
  - iBAUD_DIV changed 3 → 7 mid-frame: current frame stays at 4 cycles/bit, next frame at 8.
  - iTX_EN dropped mid-frame: frame completes, no second pop.
- Abort: iREMOVE pulse during DATA bit 3 → TXD = 1 and oBUSY = 0 next cycle, no pop that cycle. Asynchronous inRESET pulse mid-frame → TXD = 1 without a clock edge.
